// File: rtl/alu_pkg.sv
// Shared ALU operation codes and multiply/divide FSM state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_NOP   = 4'd0,
      ALU_ADD   = 4'd1,
      ALU_SUB   = 4'd2,
      ALU_AND   = 4'd3,
      ALU_OR    = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_NOR   = 4'd6,
      ALU_SLT   = 4'd7,
      ALU_SLL   = 4'd8,
      ALU_SRL   = 4'd9,
      ALU_SRA   = 4'd10,
      ALU_LUI   = 4'd11,
      ALU_MULT  = 4'd12,
      ALU_DIV   = 4'd13,
      ALU_MULTU = 4'd14,
      ALU_DIVU  = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIXUP,
      ST_DONE
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate (magnitude extraction / sign restore).
// Latency: combinational.
// Backpressure: none.
module muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_val
);

   // The most-negative value maps onto itself, which is exactly its unsigned magnitude.
   assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle signed MULT/DIV into HI/LO; MULTU/DIVU added when MULDIV_UNSIGNED_EN is defined.
// Latency: WIDTH+2 cycles start->done; divide by zero completes in 1 cycle.
// Backpressure: start is only sampled in IDLE; busy flags the caller to stall.
module iterative_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   muldiv_state_t        r_state;
   muldiv_state_t        w_next_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]     r_opnd;    // multiplicand magnitude or divisor magnitude
   logic                 r_is_div;
   logic                 r_neg_q;   // negate product / quotient
   logic                 r_neg_r;   // negate remainder
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_dbz;

   alu_op_e              w_op;
   logic                 w_op_mul;
   logic                 w_op_div;
   logic                 w_signed;
   logic                 w_b_zero;
   logic                 w_accept;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [WIDTH:0]       w_mul_sum;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH:0]       w_div_diff;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quot;
   logic [WIDTH-1:0]     w_rem;

   assign w_op = alu_op_e'(alu_operation);
`ifdef MULDIV_UNSIGNED_EN
   assign w_op_mul = (w_op == ALU_MULT) || (w_op == ALU_MULTU);
   assign w_op_div = (w_op == ALU_DIV)  || (w_op == ALU_DIVU);
   assign w_signed = (w_op == ALU_MULT) || (w_op == ALU_DIV);
`else
   assign w_op_mul = (w_op == ALU_MULT);
   assign w_op_div = (w_op == ALU_DIV);
   assign w_signed = 1'b1;
`endif
   assign w_b_zero = (b == '0);

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
      .i_val(a), .i_neg(w_signed & a[WIDTH-1]), .o_val(w_mag_a));
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
      .i_val(b), .i_neg(w_signed & b[WIDTH-1]), .o_val(w_mag_b));

   // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Restoring step: trial-subtract divisor from {remainder, next dividend bit}.
   assign w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
   assign w_div_next = w_div_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                         : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
      .i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod));
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
      .i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_q), .o_val(w_quot));
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
      .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_rem));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state, start acceptance and status decode (status depends on state only).
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && (w_op_mul || w_op_div)) begin
               w_accept     = 1'b1;
               w_next_state = (w_op_div && w_b_zero) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            busy = 1'b1;
            if (r_cnt == LAST_ITER) w_next_state = ST_FIXUP;
         end
         ST_FIXUP: begin
            busy         = 1'b1;
            w_next_state = ST_DONE;
         end
         ST_DONE: begin
            done         = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Operand capture, iteration datapath and HI/LO result load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_dbz    <= 1'b0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_is_div <= w_op_div;
         r_neg_q  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         r_neg_r  <= w_signed & a[WIDTH-1];
         r_opnd   <= w_op_div ? w_mag_b : w_mag_a;
         r_acc    <= {{WIDTH{1'b0}}, (w_op_div ? w_mag_a : w_mag_b)};
         r_dbz    <= 1'b0;
         if (w_op_div && w_b_zero) begin
            r_hi  <= a;
            r_lo  <= '1;
            r_dbz <= 1'b1;
         end
      end else if (r_state == ST_CALC) begin
         r_cnt <= r_cnt + CNT_W'(1);
         r_acc <= r_is_div ? w_div_next : w_mul_next;
      end else if (r_state == ST_FIXUP) begin
         if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
         end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
         end
      end
   end

   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iterative_muldiv.sv
module tb_iterative_muldiv;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    alu_operation = 4'd0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   iterative_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_operation(alu_operation),
      .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
      .div_by_zero(div_by_zero));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           cyc;
      string        name;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".hi"}, hi, e.hi);
            chk({e.name, ".lo"}, lo, e.lo);
            chk({e.name, ".dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
            chk({e.name, ".done_cycle"}, cyc, e.cyc);
         end
      end
   end

   task automatic pulse_start(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
      @(negedge clk);
      alu_operation = op; a = va; b = vb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Issue one operation and queue its hand-computed result; lat is start->done in cycles.
   task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edbz, input int lat);
      exp_t e;
      @(negedge clk);
      alu_operation = op; a = va; b = vb; start = 1'b1;
      e.hi = ehi; e.lo = elo; e.dbz = edbz; e.name = name;
      e.cyc = cyc + 1 + lat - 1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk({name, ".busy_after_start"}, {31'd0, busy}, {31'd0, (lat > 1)});
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!done) chk({name, ".done_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      // Reset values.
      repeat (3) @(negedge clk);
      chk("reset.busy", {31'd0, busy}, 32'd0);
      chk("reset.done", {31'd0, done}, 32'd0);
      chk("reset.hi", hi, 32'd0);
      chk("reset.lo", lo, 32'd0);
      chk("reset.dbz", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;

      issue("mult_m7x6", 4'd12, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 34);
      wait_done("mult_m7x6");
      @(negedge clk);
      chk("done_one_pulse", {31'd0, done}, 32'd0);

      issue("div_m7d2", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
      wait_done("div_m7d2");

      issue("div_7dm2", 4'd13, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34);
      wait_done("div_7dm2");

      issue("div_100d7", 4'd13, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
      wait_done("div_100d7");

      // Divide by zero: one-cycle completion, busy never asserted, flag held afterwards.
      issue("div_5d0", 4'd13, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
      wait_done("div_5d0");
      repeat (3) @(negedge clk);
      chk("dbz_held", {31'd0, div_by_zero}, 32'd1);
      chk("dbz_busy_low", {31'd0, busy}, 32'd0);

      issue("div_overflow", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);
      wait_done("div_overflow");

      // Non-muldiv opcode must not start the unit.
      pulse_start(4'd1, 32'd9, 32'd9);
      chk("nop_ignored", {31'd0, busy}, 32'd0);
`ifdef MULDIV_UNSIGNED_EN
      issue("multu", 4'd14, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 34);
      wait_done("multu");
`else
      pulse_start(4'd14, 32'hFFFF_FFFF, 32'd2);
      chk("multu_ignored", {31'd0, busy}, 32'd0);
`endif

      // A start during CALC is ignored; the first result arrives on time.
      issue("mult_100x200", 4'd12, 32'd100, 32'd200, 32'd0, 32'd20000, 1'b0, 34);
      repeat (5) @(negedge clk);
      start = 1'b1; alu_operation = 4'd12; a = 32'd7; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done("mult_100x200");
      // A start sampled in the DONE cycle is ignored.
      start = 1'b1; alu_operation = 4'd12; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
      issue("mult_3x5", 4'd12, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34);
      wait_done("mult_3x5");

      // Back-to-back: restart in the cycle right after done.
      issue("mult_b2b", 4'd12, 32'd11, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFDF, 1'b0, 34);
      wait_done("mult_b2b");

      // Reset in the middle of CALC clears everything at once.
      pulse_start(4'd12, 32'd1000, 32'd1000);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst.busy", {31'd0, busy}, 32'd0);
      chk("midrst.done", {31'd0, done}, 32'd0);
      chk("midrst.hi", hi, 32'd0);
      chk("midrst.lo", lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      issue("mult_3x4", 4'd12, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34);
      wait_done("mult_3x4");

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
